// File: rtl/seg_serial_ctrl.sv
// Serialises the 64-bit segment pattern onto the 7-seg shift-register chain and
// generates the flash phase. Optional macro SEG_CHANGE_ONLY_EN: refresh ticks only
// start a frame when the pattern differs from the last one sent.
//
// state | meaning
// IDLE  | waiting for pending request or refresh tick
// LOAD  | one cycle: snapshot seg_txt, clear pending
// SHIFT | 64 bits MSB first, each bit CLK_DIV low + CLK_DIV high
// LATCH | seg_en strobe for 2*CLK_DIV cycles
module seg_serial_ctrl #(
  parameter int CLK_DIV     = 2,
  parameter int REFRESH_CYC = 50000,
  parameter int FLASH_CYC   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] seg_txt,
  input  logic        update,
  output logic        flash,
  output logic        seg_clk,
  output logic        seg_dout,
  output logic        seg_clr_n,
  output logic        seg_en,
  output logic        busy,
  output logic        frame_done
);

  localparam int PH_W  = $clog2(2 * CLK_DIV + 1);
  localparam int REF_W = $clog2(REFRESH_CYC + 1);
  localparam int FL_W  = $clog2(FLASH_CYC + 1);

  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYC - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [63:0]      shift_reg, shift_nxt;
  logic [5:0]       bit_cnt, bit_nxt;
  logic [PH_W-1:0]  phase_cnt, phase_nxt;
  logic             pending, pending_nxt;
  logic             done_q, done_nxt;
  logic             clr_q;
  logic [REF_W-1:0] ref_cnt;
  logic [FL_W-1:0]  flash_cnt;
  logic             flash_q;
  logic             tick;
  logic             tick_req;

  assign tick = (ref_cnt == REF_LAST);

`ifdef SEG_CHANGE_ONLY_EN
  logic [63:0] last_sent;

  assign tick_req = tick && (seg_txt != last_sent);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_sent <= '0;
    end else if (state == LOAD) begin
      last_sent <= seg_txt;
    end
  end
`else
  assign tick_req = tick;
`endif

  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    bit_nxt     = bit_cnt;
    phase_nxt   = phase_cnt;
    pending_nxt = pending | update | tick_req;
    done_nxt    = 1'b0;
    busy        = 1'b0;
    seg_clk     = 1'b0;
    seg_dout    = 1'b0;
    seg_en      = 1'b0;
    case (state)
      IDLE: begin
        if (pending || tick_req) state_nxt = LOAD;
      end
      LOAD: begin
        busy        = 1'b1;
        shift_nxt   = seg_txt;
        bit_nxt     = 6'd0;
        phase_nxt   = PH_LOAD;
        // a request landing on the LOAD cycle must survive as a follow-up frame
        pending_nxt = update | tick_req;
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        seg_dout = shift_reg[63];
        seg_clk  = (phase_cnt < PH_HIGH);
        if (phase_cnt == '0) begin
          phase_nxt = PH_LOAD;
          if (bit_cnt == 6'd63) begin
            state_nxt = LATCH;
          end else begin
            bit_nxt   = bit_cnt + 6'd1;
            shift_nxt = {shift_reg[62:0], 1'b0};
          end
        end else begin
          phase_nxt = phase_cnt - PH_W'(1);
        end
      end
      LATCH: begin
        busy   = 1'b1;
        seg_en = 1'b1;
        if (phase_cnt == '0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          phase_nxt = phase_cnt - PH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      pending   <= 1'b1;
      done_q    <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_nxt;
      phase_cnt <= phase_nxt;
      pending   <= pending_nxt;
      done_q    <= done_nxt;
      clr_q     <= 1'b1;
    end
  end

  // refresh and flash timers run regardless of the sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      flash_cnt <= '0;
      flash_q   <= 1'b0;
    end else begin
      ref_cnt <= tick ? '0 : ref_cnt + REF_W'(1);
      if (flash_cnt == FL_LAST) begin
        flash_cnt <= '0;
        flash_q   <= ~flash_q;
      end else begin
        flash_cnt <= flash_cnt + FL_W'(1);
      end
    end
  end

  assign frame_done = done_q;
  assign seg_clr_n  = clr_q;
  assign flash      = flash_q;

endmodule

// File: tb/tb_seg_serial_ctrl.sv
// Bench for seg_serial_ctrl: directed scenarios plus random requests/patterns,
// checked every cycle against a frame-offset reference model.
module tb_seg_serial_ctrl;

  localparam int CLK_DIV     = 1;
  localparam int REFRESH_CYC = 300;
  localparam int FLASH_CYC   = 8;
  localparam int FRAME_LEN   = 1 + 130 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] seg_txt = '0;
  logic        update = 1'b0;
  logic        flash, seg_clk, seg_dout, seg_clr_n, seg_en, busy, frame_done;

  seg_serial_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .REFRESH_CYC(REFRESH_CYC),
    .FLASH_CYC  (FLASH_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_txt   (seg_txt),
    .update    (update),
    .flash     (flash),
    .seg_clk   (seg_clk),
    .seg_dout  (seg_dout),
    .seg_clr_n (seg_clr_n),
    .seg_en    (seg_en),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: a frame is described only by its offset from LOAD entry
  bit          m_active = 0;
  int          m_off = 0;
  logic [63:0] m_snap = '0;
  logic [63:0] m_last = '0;
  bit          m_pending = 1;
  bit          m_done = 0;
  bit          m_clr_n = 0;
  int          m_ref = 0;
  int          m_fl = 0;
  bit          m_flash = 0;

  // what the chain actually received, reconstructed from the pins
  logic [63:0] cap = '0;
  int          cap_n = 0;
  int          en_cnt = 0;
  bit          prev_clk = 0;
  bit          prev_busy = 0;
  int          n_busy_rise = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick_req;
    if (!rst_n) begin
      m_active = 0; m_off = 0; m_pending = 1; m_done = 0; m_clr_n = 0;
      m_ref = 0; m_fl = 0; m_flash = 0; m_last = '0;
      cap_n = 0; en_cnt = 0;
      return;
    end
    tick_req = (m_ref == REFRESH_CYC - 1);
`ifdef SEG_CHANGE_ONLY_EN
    if (seg_txt == m_last) tick_req = 0;
`endif
    m_done = 0;
    if (m_active) begin
      if (m_off == 0) begin
        m_snap    = seg_txt;
        m_last    = seg_txt;
        m_pending = update | tick_req;
      end else begin
        m_pending = m_pending | update | tick_req;
      end
      m_off++;
      if (m_off == FRAME_LEN) begin
        m_active = 0;
        m_done   = 1;
      end
    end else begin
      if (m_pending || tick_req) begin
        m_active = 1;
        m_off    = 0;
        cap_n    = 0;
        en_cnt   = 0;
      end
      m_pending = m_pending | update | tick_req;
    end
    m_ref = (m_ref + 1) % REFRESH_CYC;
    if (m_fl == FLASH_CYC - 1) begin
      m_fl    = 0;
      m_flash = !m_flash;
    end else begin
      m_fl++;
    end
    m_clr_n = 1;
  endtask

  task automatic check_outputs();
    bit in_shift;
    bit e_clk, e_dout, e_en;
    in_shift = m_active && m_off >= 1 && m_off <= 128 * CLK_DIV;
    e_clk  = in_shift && (((m_off - 1) % (2 * CLK_DIV)) >= CLK_DIV);
    e_dout = in_shift ? m_snap[63 - (m_off - 1) / (2 * CLK_DIV)] : 1'b0;
    e_en   = m_active && m_off > 128 * CLK_DIV;
    check_eq("busy", busy, m_active);
    check_eq("seg_clk", seg_clk, e_clk);
    check_eq("seg_dout", seg_dout, e_dout);
    check_eq("seg_en", seg_en, e_en);
    check_eq("frame_done", frame_done, m_done);
    check_eq("seg_clr_n", seg_clr_n, m_clr_n);
    check_eq("flash", flash, m_flash);
    if (seg_clk && !prev_clk) begin
      cap = {cap[62:0], seg_dout};
      cap_n++;
    end
    if (seg_en) en_cnt++;
    if (busy && !prev_busy) n_busy_rise++;
    prev_clk  = seg_clk;
    prev_busy = busy;
    if (m_done) begin
      check_eq("frame_bits", cap, m_snap);
      check_eq("frame_edges", cap_n, 64);
      check_eq("latch_cycles", en_cnt, 2 * CLK_DIV);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_update();
    update = 1'b1;
    cycle();
    update = 1'b0;
  endtask

  task automatic wait_off(input int target, input int budget);
    int i;
    i = 0;
    while (!(m_active && m_off == target) && i < budget) begin
      cycle();
      i++;
    end
    check_eq("wait_busy", busy, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    run(n);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset and first forced frame
    do_reset(3);
    check_eq("rst_clr_n", seg_clr_n, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    seg_txt = 64'hF0E1_D2C3_B4A5_9687;
    cycle();
    check_eq("post_rst_clr_n", seg_clr_n, 1'b1);
    check_eq("post_rst_busy", busy, 1'b1);
    run(140);

    // two requests during a frame merge into one follow-up
    seg_txt = {$urandom, $urandom};
    pulse_update();
    wait_off(20, 50);
    pulse_update();
    wait_off(70, 200);
    pulse_update();
    run(300);

    // pattern change mid-frame must not reach the chain
    seg_txt = {$urandom, $urandom};
    pulse_update();
    wait_off(1 + 20 * CLK_DIV, 400);
    seg_txt = '0;
    run(150);

    // reset in the middle of bit 30
    seg_txt = {$urandom, $urandom};
    pulse_update();
    wait_off(1 + 60 * CLK_DIV, 400);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("midrst_en", seg_en, 1'b0);
    check_eq("midrst_clr_n", seg_clr_n, 1'b0);
    run(150);

    // idle stretch for the flash phase
    run(64);

    // random requests, patterns and rare resets
    for (int i = 0; i < 3000; i++) begin
      update = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) seg_txt = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 1499) != 0);
      cycle();
    end
    update = 1'b0;
    rst_n  = 1'b1;
    run(200);

`ifdef SEG_CHANGE_ONLY_EN
    // constant pattern: only the post-reset frame, then one frame per change
    seg_txt = 64'h0123_4567_89AB_CDEF;
    do_reset(2);
    n_busy_rise = 0;
    run(700);
    check_eq("change_only_const", n_busy_rise, 1);
    seg_txt = 64'hDEAD_BEEF_0BAD_F00D;
    run(400);
    check_eq("change_only_new", n_busy_rise, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
